// File: rtl/pulse_event_arbiter_if.sv
// Event handshake bundle between the pulse arbiter and its consumer.
// The offered id must stay stable while valid is high.
interface pulse_event_arbiter_if #(
  parameter int N_CH = 4
);
  localparam int ID_W = $clog2(N_CH);

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/pulse_event_arbiter.sv
// Synchronizes async event strobes, latches them as pending and
// serializes them round-robin onto one valid/ready event port.
module pulse_event_arbiter #(
  parameter int N_CH       = 4,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             auto_rst,
  input  logic [N_CH-1:0]  pulse_in,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic             clr_ovf,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  ovf,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy,
  pulse_event_arbiter_if.master evt
);
  localparam int ID_W = $clog2(N_CH);
  localparam int SW   = CNT_W + $clog2(N_CH + 1);
  localparam logic [7:0] GAP = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [N_CH-1:0]  s1_q, s2_q, s3_q;
  logic [N_CH-1:0]  rise, clear, lost, elig;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [SW-1:0]    drop_sum;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  win;
  logic             found;
  logic [7:0]       gap_q, gap_d;
  logic             xfer;

  always_ff @(posedge clk or posedge auto_rst) begin
    if (auto_rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= pulse_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign xfer = valid_q & evt.evt_ready;

  always_comb begin
    clear = '0;
    for (int i = 0; i < N_CH; i++) begin
      clear[i] = xfer && (id_q == ID_W'(i));
    end
  end

  // A rise coinciding with delivery of the same channel is a new event.
  assign lost   = rise & pend_q & ~clear;
  assign pend_d = (pend_q & ~clear) | rise;
  assign ovf_d  = clr_ovf ? '0 : (ovf_q | lost);

  always_comb begin
    drop_sum = SW'(drop_q);
    for (int i = 0; i < N_CH; i++) begin
      drop_sum = drop_sum + SW'(lost[i]);
    end
    if (clr_ovf) begin
      drop_d = '0;
    end else if (|drop_sum[SW-1:CNT_W]) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[CNT_W-1:0];
    end
  end

  assign elig = pend_q & ~ch_mask;

  // Search starts just after the last winner.
  always_comb begin
    int j;
    found = 1'b0;
    win   = ptr_q;
    j     = 0;
    for (int k = 1; k <= N_CH; k++) begin
      j = (int'(ptr_q) + k) % N_CH;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge auto_rst) begin
    if (auto_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (found) state_d = GRANT;
      end
      GRANT: begin
        if (xfer) state_d = (GAP == 8'd0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (gap_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          valid_d = 1'b1;
          id_d    = win;
          ptr_d   = win;
        end
      end
      GRANT: begin
        if (xfer) begin
          valid_d = 1'b0;
          gap_d   = GAP;
        end
      end
      HOLD: begin
        gap_d = gap_q - 8'd1;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge auto_rst) begin
    if (auto_rst) begin
      pend_q  <= '0;
      ovf_q   <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= ID_W'(N_CH - 1);
      gap_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign pending       = pend_q;
  assign ovf           = ovf_q;
  assign drop_count    = drop_q;
  assign busy          = (state_q != IDLE) | (|pend_q);

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter: a GAP=0 instance and a
// GAP=3, 2-bit-counter instance driven from one clock.
module tb_pulse_event_arbiter;
  logic       clk;
  logic       rst;
  logic [3:0] pin, mask, pend, ovf;
  logic       clr, busy;
  logic [7:0] drop;
  logic [3:0] g_pin, g_mask, g_pend, g_ovf;
  logic       g_clr, g_busy;
  logic [1:0] g_drop;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ids_q[$];
  int xc_q[$];
  int gx_q[$];

  pulse_event_arbiter_if #(.N_CH(4)) bus ();
  pulse_event_arbiter_if #(.N_CH(4)) gbus ();

  pulse_event_arbiter #(
    .N_CH(4), .GAP_CYCLES(0), .CNT_W(8)
  ) u_dut (
    .clk(clk), .auto_rst(rst),
    .pulse_in(pin), .ch_mask(mask), .clr_ovf(clr),
    .pending(pend), .ovf(ovf), .drop_count(drop),
    .busy(busy), .evt(bus.master)
  );

  pulse_event_arbiter #(
    .N_CH(4), .GAP_CYCLES(3), .CNT_W(2)
  ) u_gap (
    .clk(clk), .auto_rst(rst),
    .pulse_in(g_pin), .ch_mask(g_mask), .clr_ovf(g_clr),
    .pending(g_pend), .ovf(g_ovf), .drop_count(g_drop),
    .busy(g_busy), .evt(gbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake inputs are stable between posedge+1 and the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (bus.evt_valid && bus.evt_ready) begin
      ids_q.push_back(int'(bus.evt_id));
      xc_q.push_back(cyc);
    end
    if (gbus.evt_valid && gbus.evt_ready) gx_q.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    pin = '0; mask = '0; clr = 1'b0;
    g_pin = '0; g_mask = '0; g_clr = 1'b0;
    bus.evt_ready = 1'b0;
    gbus.evt_ready = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    ids_q.delete();
    xc_q.delete();
    gx_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    check("rst_valid", bus.evt_valid, 0);
    check("rst_pend", pend, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop, 0);
    check("rst_busy", busy, 0);

    // single event on ch2
    bus.evt_ready = 1'b1;
    pin = 4'b0100;
    step(3);
    check("t1_pend", pend, 4'b0100);
    check("t1_nvalid", bus.evt_valid, 0);
    pin = '0;
    step(1);
    check("t1_valid", bus.evt_valid, 1);
    check("t1_id", bus.evt_id, 2);
    check("t1_busy", busy, 1);
    step(1);
    check("t1_done", bus.evt_valid, 0);
    check("t1_pend0", pend, 0);
    check("t1_idle", busy, 0);
    step(4);
    check("t1_cnt", ids_q.size(), 1);
    check("t1_ev", ids_q[0], 2);

    // round robin 0,1,3 then 0,1
    do_reset();
    bus.evt_ready = 1'b1;
    pin = 4'b1011;
    step(3);
    pin = '0;
    step(10);
    check("t2_cnt", ids_q.size(), 3);
    check("t2_id0", ids_q[0], 0);
    check("t2_id1", ids_q[1], 1);
    check("t2_id2", ids_q[2], 3);
    check("t2_gap01", xc_q[1] - xc_q[0], 2);
    check("t2_gap12", xc_q[2] - xc_q[1], 2);
    pin = 4'b0011;
    step(3);
    pin = '0;
    step(8);
    check("t2_cnt2", ids_q.size(), 5);
    check("t2_id3", ids_q[3], 0);
    check("t2_id4", ids_q[4], 1);

    // overflow while ch1 is stalled
    do_reset();
    for (int i = 0; i < 12; i++) begin
      pin[1] = (i < 3) || (i >= 6 && i < 9);
      step(1);
    end
    check("t3_valid", bus.evt_valid, 1);
    check("t3_id", bus.evt_id, 1);
    check("t3_ovf", ovf, 4'b0010);
    check("t3_drop", drop, 1);
    check("t3_pend", pend, 4'b0010);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t3_clr_ovf", ovf, 0);
    check("t3_clr_drop", drop, 0);
    check("t3_hold", bus.evt_valid, 1);
    pin = 4'b0010;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    pin = '0;
    check("t3_clrwin_ovf", ovf, 0);
    check("t3_clrwin_drop", drop, 0);
    step(3);
    pin = 4'b0101;
    step(3);
    pin = '0;
    step(3);
    pin = 4'b0101;
    step(3);
    pin = '0;
    step(3);
    check("t3_multi_drop", drop, 2);
    check("t3_multi_ovf", ovf, 4'b0101);
    check("t3_id_stable", bus.evt_id, 1);
    bus.evt_ready = 1'b1;
    step(1);
    check("t3_xfer_pend", pend, 4'b0101);
    check("t3_xfer_valid", bus.evt_valid, 0);
    step(8);
    check("t3_cnt", ids_q.size(), 3);
    check("t3_rr1", ids_q[1], 2);
    check("t3_rr2", ids_q[2], 0);

    // masked ch0
    do_reset();
    mask = 4'b0001;
    bus.evt_ready = 1'b1;
    pin = 4'b0101;
    step(3);
    pin = '0;
    step(8);
    check("t4_cnt", ids_q.size(), 1);
    check("t4_id", ids_q[0], 2);
    check("t4_pend", pend, 4'b0001);
    check("t4_busy", busy, 1);
    mask = '0;
    step(3);
    check("t4_cnt2", ids_q.size(), 2);
    check("t4_id2", ids_q[1], 0);
    check("t4_pend0", pend, 0);

    // GAP_CYCLES=3 spacing
    do_reset();
    gbus.evt_ready = 1'b1;
    g_pin = 4'b0011;
    step(3);
    g_pin = '0;
    step(12);
    check("t5_cnt", gx_q.size(), 2);
    check("t5_gap", gx_q[1] - gx_q[0], 5);

    // 2-bit drop counter saturation
    do_reset();
    for (int j = 0; j < 5; j++) begin
      g_pin = 4'b1000;
      step(3);
      g_pin = '0;
      step(3);
      if (j == 2) check("t5_drop2", g_drop, 2);
    end
    check("t5_sat", g_drop, 3);
    check("t5_govf", g_ovf, 4'b1000);

    // reset while granting
    do_reset();
    pin = 4'b0010;
    step(3);
    pin = '0;
    step(3);
    pin = 4'b0010;
    step(3);
    pin = '0;
    step(3);
    check("t6_pre_valid", bus.evt_valid, 1);
    check("t6_pre_ovf", ovf, 4'b0010);
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", bus.evt_valid, 0);
    check("t6_pend", pend, 0);
    check("t6_ovf", ovf, 0);
    check("t6_drop", drop, 0);
    step(1);
    rst = 1'b0;
    step(1);
    ids_q.delete();
    bus.evt_ready = 1'b1;
    pin = 4'b1001;
    step(3);
    pin = '0;
    step(6);
    check("t6_cnt", ids_q.size(), 2);
    check("t6_first", ids_q[0], 0);
    check("t6_second", ids_q[1], 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
